cordic_ci_seq: RTL
==================

CORDIC_CI_SEQ -- requirements
Module: cordic_ci_seq

Interface
REQ-001 Parameter PIPE_LATENCY, default 16, legal 1..255: clock-enabled cycles from operand presentation to a valid result at the downstream CORDIC pipeline output.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 aclr_n  input  1  asynchronous, active-low reset.
REQ-004 clk_en  input  1  host clock enable; low freezes all sequencer state.
REQ-005 start  input  1  host request; sampled only when clk_en=1.
REQ-006 dataa  input  32  host operand (angle word); sampled with start.
REQ-007 done  output  1  one-cycle result-valid strobe to host.
REQ-008 result  output  32  captured cosine result; held between operations.
REQ-009 busy  output  1  high while an operation is in flight (state RUN or CAPT).
REQ-010 overrun  output  1  sticky: a start arrived while busy.
REQ-011 lat_count  output  16  total clock cycles, stalls included, from accepted start to done of the last operation.
REQ-012 pipe_aclr  output  1  active-high clear to the downstream pipeline.
REQ-013 pipe_clk_en  output  1  clock enable to the downstream pipeline.
REQ-014 pipe_dataa  output  32  operand to the downstream pipeline.
REQ-015 pipe_result  input  32  result from the downstream pipeline.

Function
REQ-016 FSM states: IDLE, RUN, CAPT; encoding is free; no other reachable states.
REQ-017 No state, counter or output register shall change in any cycle with clk_en=0, except the lat_count accumulator and pipe_aclr.
REQ-018 IDLE with clk_en=1 and start=1: latch dataa into the operand register, load the step counter with PIPE_LATENCY, clear the cycle accumulator to 1, and go to RUN.
REQ-019 pipe_dataa shall equal the operand register at all times.
REQ-020 pipe_clk_en shall equal clk_en in every state.
REQ-021 RUN with clk_en=1: decrement the step counter; when it reaches 0 in that update, go to CAPT.
REQ-022 CAPT with clk_en=1: register pipe_result into result, assert done for exactly that following cycle, copy the accumulator into lat_count, and return to IDLE.
REQ-023 With clk_en held at 1, done shall rise PIPE_LATENCY+2 edges after the edge that accepts start.
REQ-024 The accumulator shall increment on every edge while busy, regardless of clk_en, and saturate at 16'hFFFF.
REQ-025 A start in RUN or CAPT is ignored (no operand or counter change) and sets overrun to 1; only reset clears overrun.
REQ-026 A start in the same cycle that done is high is accepted normally (the state is IDLE then).
REQ-027 done shall be low in any cycle not defined by REQ-022; result and lat_count hold their values until the next capture.
REQ-028 busy shall be combinationally (state != IDLE).

Reset
REQ-029 With aclr_n=0, the following shall apply immediately and hold: state IDLE, done=0, busy=0, overrun=0, result=0, lat_count=0, operand=0, step counter=0, accumulator=0.
REQ-030 pipe_aclr shall equal the inverse of aclr_n (combinational) so the pipeline clears with the sequencer.
REQ-031 Reset asserted mid-operation aborts the operation with no done pulse; the first start after release is processed normally.
REQ-032 aclr_n release is synchronised internally (two-flop) before the FSM may leave IDLE.

Verification
REQ-033 PIPE_LATENCY=16, clk_en=1, start pulse with dataa=32'h3F000000, pipe_result model driven to 32'h3F60A940 -> done high once, 18 edges after acceptance; result=32'h3F60A940; lat_count=18.
REQ-034 Same stimulus, clk_en held low for 5 cycles during RUN -> done delayed by 5; lat_count=23; result is unchanged from the pipe_result value.
REQ-035 Second start issued 4 cycles after the first -> overrun=1; operand stays at the first dataa; exactly one done.
REQ-036 aclr_n pulsed low at cycle 8 of RUN -> busy=0 and result=0 immediately; no done; pipe_aclr=1 during the pulse; a later start completes in 18 edges.
REQ-037 Back-to-back operations: start asserted in the done cycle -> accepted; second done follows 18 edges later; overrun stays 0.
REQ-038 PIPE_LATENCY=1 -> done 3 edges after acceptance; lat_count=3.

Source files
------------

// File: rtl/cordic_ci_seq.sv
// Host-side sequencer for a fixed-latency CORDIC pipeline: launches one operand,
// waits PIPE_LATENCY enabled cycles, captures the cosine result and strobes done.
module cordic_ci_seq #(
   parameter int unsigned PIPE_LATENCY = 16
) (
   input  logic        clock,
   input  logic        aclr_n,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   output logic        done,
   output logic [31:0] result,
   output logic        busy,
   output logic        overrun,
   output logic [15:0] lat_count,
   output logic        pipe_aclr,
   output logic        pipe_clk_en,
   output logic [31:0] pipe_dataa,
   input  logic [31:0] pipe_result
);

   localparam int unsigned DW = 32;
   localparam int unsigned LW = 16;
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      CAPT = 2'd2
   } state_t;

   state_t         state;
   logic [DW-1:0]  operand;
   logic [CW-1:0]  step;
   logic [LW-1:0]  acc;
   logic           done_pend;
   logic [1:0]     rst_sync;
   logic           run_ok;

   // Release of aclr_n is re-timed so the FSM never starts on a metastable edge
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) rst_sync <= 2'b00;
      else         rst_sync <= {rst_sync[0], 1'b1};
   end

   assign run_ok      = rst_sync[1];
   assign busy        = (state != IDLE);
   assign pipe_aclr   = ~aclr_n;
   assign pipe_clk_en = clk_en;
   assign pipe_dataa  = operand;

   // Sequencer: the accumulator free-runs while busy, everything else is clk_en gated
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         state     <= IDLE;
         operand   <= '0;
         step      <= '0;
         acc       <= '0;
         done_pend <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         overrun   <= 1'b0;
         lat_count <= '0;
      end else begin
         if (busy && (acc != {LW{1'b1}})) acc <= acc + LW'(1);
         if (clk_en) begin
            done      <= done_pend;
            done_pend <= 1'b0;
            if (done_pend) lat_count <= acc;
            case (state)
               IDLE: begin
                  if (start && run_ok) begin
                     operand <= dataa;
                     step    <= CW'(PIPE_LATENCY);
                     acc     <= LW'(1);
                     state   <= RUN;
                  end
               end
               RUN: begin
                  if (start) overrun <= 1'b1;
                  step <= step - CW'(1);
                  if (step == CW'(1)) state <= CAPT;
               end
               CAPT: begin
                  if (start) overrun <= 1'b1;
                  result    <= pipe_result;
                  done_pend <= 1'b1;
                  state     <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
